// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control stage.
// States, instruction classes, opcode fields and mux/ALU encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRIMM,
        GETA,
        GETB,
        EXEC,
        WRITE,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ILL,
        C_MOVI,
        C_MOVR,
        C_MVN,
        C_ADDAND,
        C_CMP,
        C_HALT
    } cls_t;

    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder.
// Splits the IR into fields, sign-extends immediates, classifies.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [1:0]  op_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  sh_o,
    output logic [15:0] sximm5_o,
    output logic [15:0] sximm8_o,
    output cls_t        cls_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign rm_o     = ir_i[2:0];
    assign sh_o     = ir_i[4:3];
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

    always_comb begin
        cls_o = C_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op_o == OP_MOVI)
                    cls_o = C_MOVI;
                else if (op_o == OP_MOVR)
                    cls_o = C_MOVR;
            end
            OPC_ALU: begin
                case (op_o)
                    OP_ADD:  cls_o = C_ADDAND;
                    OP_AND:  cls_o = C_ADDAND;
                    OP_CMP:  cls_o = C_CMP;
                    default: cls_o = C_MVN;
                endcase
            end
            OPC_HALT: cls_o = C_HALT;
            default:  cls_o = C_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control stage: instruction register, Moore FSM
// sequencing regfile/ALU strobes, sticky illegal-opcode flag.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        ill_q, ill_d;

    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    cls_t        cls;

    logic write_r, loada_r, loadb_r, loadc_r, loads_r;

    instr_decoder u_dec (
        .ir_i     (ir_q),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sh_o     (shift),
        .sximm5_o (sximm5),
        .sximm8_o (sximm8),
        .cls_o    (cls)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= WAIT;
            ir_q    <= 16'h0000;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        ill_d    = ill_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = VSEL_C;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = op;
        write_r  = 1'b0;
        loada_r  = 1'b0;
        loadb_r  = 1'b0;
        loadc_r  = 1'b0;
        loads_r  = 1'b0;
        unique case (state_q)
            WAIT: begin
                w = 1'b1;
                if (load)
                    ir_d = in;
                if (s) begin
                    state_d = DECODE;
                    ill_d   = 1'b0;
                end
            end
            DECODE: begin
                unique case (cls)
                    C_MOVI:   state_d = WRIMM;
                    C_MOVR:   state_d = GETB;
                    C_MVN:    state_d = GETB;
                    C_ADDAND: state_d = GETA;
                    C_CMP:    state_d = GETA;
                    C_HALT:   state_d = HALT;
                    default: begin
                        state_d = WAIT;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            WRIMM: begin
                writenum = rn;
                vsel     = VSEL_IMM8;
                write_r  = 1'b1;
                state_d  = WAIT;
            end
            GETA: begin
                readnum = rn;
                loada_r = 1'b1;
                state_d = GETB;
            end
            GETB: begin
                readnum = rm;
                loadb_r = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                // MOV reg passes B through the adder with A forced to zero
                asel  = (cls == C_MOVR);
                ALUop = asel ? ALU_ADD : op;
                if (cls == C_CMP) begin
                    loads_r = 1'b1;
                    state_d = WAIT;
                end else begin
                    loadc_r = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                writenum = rd;
                vsel     = VSEL_C;
                write_r  = 1'b1;
                state_d  = WAIT;
            end
            default: state_d = HALT;
        endcase
    end

    assign illegal = ill_q;
    assign write   = write_r & reset_n;
    assign loada   = loada_r & reset_n;
    assign loadb   = loadb_r & reset_n;
    assign loadc   = loadc_r & reset_n;
    assign loads   = loads_r & reset_n;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller.
// One task per scenario; expected values are hand-derived constants.
module tb_cpu_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic        illegal;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    int pass_cnt;
    int total_cnt;

    cpu_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .s        (s),
        .w        (w),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] instr);
        in   = instr;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
    endtask

    function automatic logic [7:0] strobes();
        return {write, loada, loadb, loadc, loads, asel, bsel, w};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        in      = 16'h0000;
        load    = 1'b0;
        s       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        total_cnt++;
        if (strobes() !== 8'b0000_0001)
            $display("FAIL reset_strobes got=%b exp=%b", strobes(), 8'b0000_0001);
        else
            pass_cnt++;
        total_cnt++;
        if ({illegal, readnum, writenum, vsel, sximm8} !== 25'd0)
            $display("FAIL reset_fields got=%b/%h/%h/%b/%h exp=0",
                     illegal, readnum, writenum, vsel, sximm8);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid_add();
        logic saw_write;
        saw_write = 1'b0;
        start(16'hA0A1);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        if (write) saw_write = 1'b1;
        total_cnt++;
        if (loadc !== 1'b0)
            $display("FAIL rst_force_loadc got=%b exp=0", loadc);
        else
            pass_cnt++;
        tick();
        if (write) saw_write = 1'b1;
        tick();
        if (write) saw_write = 1'b1;
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if (strobes() !== 8'b0000_0001)
            $display("FAIL rst_mid_add got=%b exp=%b", strobes(), 8'b0000_0001);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (saw_write !== 1'b0 || w !== 1'b1)
            $display("FAIL rst_no_write got=%b/%b exp=0/1", saw_write, w);
        else
            pass_cnt++;
    endtask

    task automatic test_mov_imm();
        start(16'hD207);
        total_cnt++;
        if (w !== 1'b0 || write !== 1'b0)
            $display("FAIL movi_decode got w=%b wr=%b exp 0/0", w, write);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({write, writenum, vsel, sximm8} !== {1'b1, 3'd2, 2'b10, 16'h0007})
            $display("FAIL movi_wr got=%b/%0d/%b/%h exp=1/2/10/0007",
                     write, writenum, vsel, sximm8);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (w !== 1'b1 || write !== 1'b0)
            $display("FAIL movi_done got w=%b wr=%b exp 1/0", w, write);
        else
            pass_cnt++;
        start(16'hD2FB);
        tick();
        total_cnt++;
        if ({write, writenum, sximm8, sximm5} !== {1'b1, 3'd2, 16'hFFFB, 16'hFFFB})
            $display("FAIL movi_neg got=%b/%0d/%h/%h exp=1/2/fffb/fffb",
                     write, writenum, sximm8, sximm5);
        else
            pass_cnt++;
        tick();
    endtask

    task automatic test_add();
        start(16'hA0A1);
        tick();
        total_cnt++;
        if ({loada, loadb, readnum} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL add_geta got=%b/%b/%0d exp=1/0/0", loada, loadb, readnum);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({loada, loadb, readnum} !== {1'b0, 1'b1, 3'd1})
            $display("FAIL add_getb got=%b/%b/%0d exp=0/1/1", loada, loadb, readnum);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({loadc, loads, asel, ALUop, write} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0})
            $display("FAIL add_exec got=%b/%b/%b/%b/%b exp=1/0/0/00/0",
                     loadc, loads, asel, ALUop, write);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({write, writenum, vsel, loadc} !== {1'b1, 3'd5, 2'b00, 1'b0})
            $display("FAIL add_write got=%b/%0d/%b/%b exp=1/5/00/0",
                     write, writenum, vsel, loadc);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (w !== 1'b1)
            $display("FAIL add_done got=%b exp=1", w);
        else
            pass_cnt++;
    endtask

    task automatic test_cmp();
        start(16'hA90A);
        tick();
        total_cnt++;
        if ({loada, readnum} !== {1'b1, 3'd1})
            $display("FAIL cmp_geta got=%b/%0d exp=1/1", loada, readnum);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({loadb, readnum} !== {1'b1, 3'd2})
            $display("FAIL cmp_getb got=%b/%0d exp=1/2", loadb, readnum);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({shift, loads, loadc, write, ALUop} !== {2'b01, 1'b1, 1'b0, 1'b0, 2'b01})
            $display("FAIL cmp_exec got=%b/%b/%b/%b/%b exp=01/1/0/0/01",
                     shift, loads, loadc, write, ALUop);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (w !== 1'b1 || write !== 1'b0)
            $display("FAIL cmp_done got w=%b wr=%b exp 1/0", w, write);
        else
            pass_cnt++;
    endtask

    task automatic test_illegal();
        start(16'h0000);
        total_cnt++;
        if (w !== 1'b0)
            $display("FAIL ill_decode got=%b exp=0", w);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (w !== 1'b1 || illegal !== 1'b1)
            $display("FAIL ill_set got w=%b ill=%b exp 1/1", w, illegal);
        else
            pass_cnt++;
        start(16'hD207);
        total_cnt++;
        if (illegal !== 1'b0)
            $display("FAIL ill_clear got=%b exp=0", illegal);
        else
            pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int bad;
        start(16'hC0E1);
        tick();
        total_cnt++;
        if ({loadb, readnum} !== {1'b1, 3'd1})
            $display("FAIL movr_getb got=%b/%0d exp=1/1", loadb, readnum);
        else
            pass_cnt++;
        in   = 16'hFFFF;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
        total_cnt++;
        if ({asel, loadc, ALUop, sximm8} !== {1'b1, 1'b1, 2'b00, 16'hFFE1})
            $display("FAIL movr_exec got=%b/%b/%b/%h exp=1/1/00/ffe1",
                     asel, loadc, ALUop, sximm8);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if ({write, writenum, vsel} !== {1'b1, 3'd7, 2'b00})
            $display("FAIL movr_write got=%b/%0d/%b exp=1/7/00", write, writenum, vsel);
        else
            pass_cnt++;
        tick();
        total_cnt++;
        if (w !== 1'b1 || sximm8 !== 16'hFFE1)
            $display("FAIL movr_done got w=%b imm=%h exp 1/ffe1", w, sximm8);
        else
            pass_cnt++;
        start(16'hE000);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            s    = i[0];
            load = i[1];
            in   = 16'hD207;
            tick();
            if (w !== 1'b0 || write !== 1'b0) bad++;
        end
        s    = 1'b0;
        load = 1'b0;
        total_cnt++;
        if (bad !== 0)
            $display("FAIL halt_hold got=%0d bad cycles exp=0", bad);
        else
            pass_cnt++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total_cnt++;
        if (w !== 1'b1)
            $display("FAIL halt_reset got=%b exp=1", w);
        else
            pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_mov_imm();
        test_add();
        test_reset_mid_add();
        test_cmp();
        test_illegal();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
